// File: rtl/dns_req_scheduler_pkg.sv
// Shared types and widths for the DNS request scheduler.
//   ADDR_W / IP_W      : web address and resolved IP widths
//   dns_sched_state_t  : scheduler FSM states
//   dns_resp_t         : one captured response record
package dns_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned IP_W   = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } dns_sched_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [IP_W-1:0]   ip;
      logic              ok;
      logic              timeout;
      logic [7:0]        cycles;
   } dns_resp_t;

endpackage

// File: rtl/dns_req_fifo.sv
// Circular request FIFO with wrapping pointers and an occupancy count.
//   clk, rst   : clock, synchronous active-low reset
//   push       : write push_data when not full
//   pop        : drop the head entry when not empty
//   push_data  : entry to write
//   pop_data   : current head entry
//   full/empty : derived from the registered count
//   count      : occupancy, 0..DEPTH
module dns_req_fifo
   import dns_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             push_data,
   output logic [W-1:0]             pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] rptr_q;
   logic [PW:0]   count_q;
   logic          push_ok;
   logic          pop_ok;

   assign full     = (count_q == (PW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rptr_q];
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap by natural overflow
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop_ok)  rptr_q <= rptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= push_data;
   end

endmodule

// File: rtl/dns_req_scheduler.sv
// Queues lookup requests and issues them one at a time to DNSLookup.
//   clk, rst                  : clock, synchronous active-low reset
//   enq_valid/enq_addr        : request input; enq_ready = FIFO not full
//   client_req/web_addr       : one-cycle request pulse with held address
//   client_res/ip_resolved/web_ip : DNSLookup completion inputs
//   resp_valid + resp_*       : one response record per request, FIFO order
//   pending                   : FIFO occupancy
module dns_req_scheduler
   import dns_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 200
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enq_valid,
   input  logic [ADDR_W-1:0]      enq_addr,
   output logic                   enq_ready,
   output logic                   client_req,
   output logic [ADDR_W-1:0]      web_addr,
   input  logic                   client_res,
   input  logic                   ip_resolved,
   input  logic [IP_W-1:0]        web_ip,
   output logic                   resp_valid,
   output logic [ADDR_W-1:0]      resp_addr,
   output logic [IP_W-1:0]        resp_ip,
   output logic                   resp_ok,
   output logic                   resp_timeout,
   output logic [7:0]             resp_cycles,
   output logic [$clog2(DEPTH):0] pending
);

   dns_sched_state_t  state_q;
   logic [7:0]        wait_cnt_q;
   logic [ADDR_W-1:0] web_addr_q;
   logic              client_req_q;
   logic              resp_valid_q;
   dns_resp_t         resp_q;

   logic [ADDR_W-1:0] head;
   logic              full;
   logic              empty;
   logic              timeout_hit;
   logic              pop;

   assign timeout_hit = (wait_cnt_q == 8'(TIMEOUT - 1));
   // The head is retired on the edge that leaves WAIT, whichever way it ends
   assign pop         = (state_q == WAIT) && (client_res || timeout_hit);

   dns_req_fifo #(
      .DEPTH (DEPTH),
      .W     (ADDR_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (enq_valid),
      .pop       (pop),
      .push_data (enq_addr),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .count     (pending)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         wait_cnt_q   <= '0;
         web_addr_q   <= '0;
         client_req_q <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_q       <= '0;
      end else begin
         client_req_q <= 1'b0;
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!empty) begin
                  web_addr_q   <= head;
                  wait_cnt_q   <= '0;
                  client_req_q <= 1'b1;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: state_q <= WAIT;
            WAIT: begin
               wait_cnt_q <= wait_cnt_q + 8'd1;
               // A completion on the timeout cycle takes priority
               if (client_res) begin
                  resp_q.addr    <= web_addr_q;
                  resp_q.ip      <= ip_resolved ? web_ip : '0;
                  resp_q.ok      <= ip_resolved;
                  resp_q.timeout <= 1'b0;
                  resp_q.cycles  <= wait_cnt_q + 8'd1;
                  resp_valid_q   <= 1'b1;
                  state_q        <= DONE;
               end else if (timeout_hit) begin
                  resp_q.addr    <= web_addr_q;
                  resp_q.ip      <= '0;
                  resp_q.ok      <= 1'b0;
                  resp_q.timeout <= 1'b1;
                  resp_q.cycles  <= 8'(TIMEOUT);
                  resp_valid_q   <= 1'b1;
                  state_q        <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign enq_ready    = !full;
   assign client_req   = client_req_q;
   assign web_addr     = web_addr_q;
   assign resp_valid   = resp_valid_q;
   assign resp_addr    = resp_q.addr;
   assign resp_ip      = resp_q.ip;
   assign resp_ok      = resp_q.ok;
   assign resp_timeout = resp_q.timeout;
   assign resp_cycles  = resp_q.cycles;

endmodule

// File: tb/tb_dns_req_scheduler.sv
// Directed bench: instance a uses default TIMEOUT=200, instance b TIMEOUT=10.
module tb_dns_req_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // instance a
   logic       a_enq_valid = 1'b0, a_enq_ready, a_client_req, a_client_res = 1'b0;
   logic       a_ip_resolved = 1'b0, a_resp_valid, a_resp_ok, a_resp_timeout;
   logic [7:0] a_enq_addr = '0, a_web_addr, a_web_ip = '0, a_resp_addr, a_resp_ip, a_resp_cycles;
   logic [2:0] a_pending;
   // instance b
   logic       b_enq_valid = 1'b0, b_enq_ready, b_client_req, b_client_res = 1'b0;
   logic       b_ip_resolved = 1'b0, b_resp_valid, b_resp_ok, b_resp_timeout;
   logic [7:0] b_enq_addr = '0, b_web_addr, b_web_ip = '0, b_resp_addr, b_resp_ip, b_resp_cycles;
   logic [2:0] b_pending;

   int n_checks = 0;
   int n_fail   = 0;

   dns_req_scheduler #(.DEPTH(4), .TIMEOUT(200)) u_a (
      .clk(clk), .rst(rst), .enq_valid(a_enq_valid), .enq_addr(a_enq_addr), .enq_ready(a_enq_ready),
      .client_req(a_client_req), .web_addr(a_web_addr), .client_res(a_client_res),
      .ip_resolved(a_ip_resolved), .web_ip(a_web_ip), .resp_valid(a_resp_valid),
      .resp_addr(a_resp_addr), .resp_ip(a_resp_ip), .resp_ok(a_resp_ok),
      .resp_timeout(a_resp_timeout), .resp_cycles(a_resp_cycles), .pending(a_pending));

   dns_req_scheduler #(.DEPTH(4), .TIMEOUT(10)) u_b (
      .clk(clk), .rst(rst), .enq_valid(b_enq_valid), .enq_addr(b_enq_addr), .enq_ready(b_enq_ready),
      .client_req(b_client_req), .web_addr(b_web_addr), .client_res(b_client_res),
      .ip_resolved(b_ip_resolved), .web_ip(b_web_ip), .resp_valid(b_resp_valid),
      .resp_addr(b_resp_addr), .resp_ip(b_resp_ip), .resp_ok(b_resp_ok),
      .resp_timeout(b_resp_timeout), .resp_cycles(b_resp_cycles), .pending(b_pending));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Step until instance a raises client_req (bounded)
   task automatic a_wait_issue();
      int n = 0;
      while (a_client_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("a_issue_seen", 32'(a_client_req), 1);
   endtask

   // Called in the ISSUE cycle: respond in WAIT cycle k, so resp_cycles must be k
   task automatic a_respond(input int k, input logic ok, input logic [7:0] ip, input logic [7:0] addr);
      int pulses = 0;
      repeat (k) begin
         step();
         if (a_client_req === 1'b1) pulses++;
      end
      chk("a_single_pulse", pulses, 0);
      chk("a_addr_held", a_web_addr, addr);
      a_client_res  = 1'b1;
      a_ip_resolved = ok;
      a_web_ip      = ip;
      step();
      a_client_res  = 1'b0;
      a_ip_resolved = 1'b0;
      a_web_ip      = '0;
      chk("a_resp_valid", a_resp_valid, 1);
      chk("a_resp_cycles", a_resp_cycles, 32'(k));
   endtask

   initial begin
      int n;
      int hits_v;
      int hits_r;

      // ---------------- reset ----------------
      rst = 1'b0;
      step();
      step();
      chk("rst_enq_ready", a_enq_ready, 1);
      chk("rst_client_req", a_client_req, 0);
      chk("rst_web_addr", a_web_addr, 0);
      chk("rst_resp_valid", a_resp_valid, 0);
      chk("rst_resp_bus", {a_resp_addr, a_resp_ip, a_resp_cycles, a_resp_ok, a_resp_timeout}, 0);
      chk("rst_pending", a_pending, 0);
      chk("rst_b_enq_ready", b_enq_ready, 1);
      chk("rst_b_pending", b_pending, 0);
      rst = 1'b1;

      // ---------------- single lookup ----------------
      a_enq_valid = 1'b1;
      a_enq_addr  = 8'h9A;
      step();
      a_enq_valid = 1'b0;
      chk("single_pending1", a_pending, 1);
      chk("single_no_req_yet", a_client_req, 0);
      step();
      chk("single_req", a_client_req, 1);
      chk("single_web_addr", a_web_addr, 8'h9A);
      a_respond(12, 1'b1, 8'h42, 8'h9A);
      chk("single_resp_addr", a_resp_addr, 8'h9A);
      chk("single_resp_ip", a_resp_ip, 8'h42);
      chk("single_resp_ok", a_resp_ok, 1);
      chk("single_resp_to", a_resp_timeout, 0);
      chk("single_pending0", a_pending, 0);
      step();
      chk("single_valid_drop", a_resp_valid, 0);
      chk("single_ip_held", a_resp_ip, 8'h42);

      // ---------------- ordering / full ----------------
      a_enq_valid = 1'b1;
      a_enq_addr = 8'h9A; step();
      a_enq_addr = 8'h3E; step();
      a_enq_addr = 8'h11; step();
      a_enq_addr = 8'h22; step();
      chk("full_pending4", a_pending, 4);
      chk("full_not_ready", a_enq_ready, 0);
      a_enq_addr = 8'h55; step();
      chk("full_reject", a_pending, 4);
      // now in WAIT cycle 3 for 9A; keep offering 55 across the pop edge
      a_client_res  = 1'b1;
      a_ip_resolved = 1'b1;
      a_web_ip      = 8'h01;
      step();
      a_client_res  = 1'b0;
      a_ip_resolved = 1'b0;
      a_enq_valid   = 1'b0;
      chk("ord0_valid", a_resp_valid, 1);
      chk("ord0_addr", a_resp_addr, 8'h9A);
      chk("ord0_cycles", a_resp_cycles, 3);
      chk("full_pop_no_push", a_pending, 3);
      chk("ready_after_pop", a_enq_ready, 1);
      // DONE, IDLE, then ISSUE
      step();
      chk("gap_idle", a_client_req, 0);
      step();
      chk("gap_issue", a_client_req, 1);
      chk("ord1_web_addr", a_web_addr, 8'h3E);
      // unresolved
      a_respond(4, 1'b0, 8'hFF, 8'h3E);
      chk("ord1_addr", a_resp_addr, 8'h3E);
      chk("unres_ok", a_resp_ok, 0);
      chk("unres_ip", a_resp_ip, 0);
      chk("unres_to", a_resp_timeout, 0);
      a_wait_issue();
      chk("ord2_web_addr", a_web_addr, 8'h11);
      a_respond(1, 1'b1, 8'hC3, 8'h11);
      chk("ord2_addr", a_resp_addr, 8'h11);
      chk("ord2_ip", a_resp_ip, 8'hC3);
      a_wait_issue();
      chk("ord3_web_addr", a_web_addr, 8'h22);
      a_respond(5, 1'b1, 8'h5A, 8'h22);
      chk("ord3_addr", a_resp_addr, 8'h22);
      chk("ord_empty", a_pending, 0);
      // client_res while idle is ignored
      step();
      a_client_res = 1'b1;
      step();
      a_client_res = 1'b0;
      step();
      chk("idle_res_valid", a_resp_valid, 0);
      chk("idle_res_req", a_client_req, 0);
      chk("idle_res_pending", a_pending, 0);

      // ---------------- timeout (instance b) ----------------
      b_enq_valid = 1'b1;
      b_enq_addr = 8'hA1; step();
      b_enq_addr = 8'hB2; step();
      b_enq_valid = 1'b0;
      chk("to_issue", b_client_req, 1);
      chk("to_web_addr", b_web_addr, 8'hA1);
      n = 0;
      while (b_resp_valid !== 1'b1 && n < 30) begin
         step();
         n++;
      end
      // ISSUE edge plus ten WAIT cycles
      chk("to_latency", n, 11);
      chk("to_flag", b_resp_timeout, 1);
      chk("to_cycles", b_resp_cycles, 10);
      chk("to_ok", b_resp_ok, 0);
      chk("to_ip", b_resp_ip, 0);
      chk("to_addr", b_resp_addr, 8'hA1);
      chk("to_pending", b_pending, 1);
      step();
      chk("to_gap_idle", b_client_req, 0);
      step();
      chk("to_gap_issue", b_client_req, 1);
      chk("to_next_addr", b_web_addr, 8'hB2);
      // completion on the exact timeout cycle
      repeat (10) step();
      b_client_res  = 1'b1;
      b_ip_resolved = 1'b1;
      b_web_ip      = 8'h77;
      step();
      b_client_res  = 1'b0;
      b_ip_resolved = 1'b0;
      b_web_ip      = '0;
      chk("race_valid", b_resp_valid, 1);
      chk("race_to", b_resp_timeout, 0);
      chk("race_ok", b_resp_ok, 1);
      chk("race_ip", b_resp_ip, 8'h77);
      chk("race_cycles", b_resp_cycles, 10);

      // ---------------- reset mid-WAIT ----------------
      step();
      b_enq_valid = 1'b1;
      b_enq_addr = 8'hC1; step();
      b_enq_addr = 8'hC2; step();
      b_enq_valid = 1'b0;
      step();
      step();
      chk("mid_pending2", b_pending, 2);
      rst = 1'b0;
      step();
      chk("mid_rst_pending", b_pending, 0);
      chk("mid_rst_valid", b_resp_valid, 0);
      rst = 1'b1;
      step();
      b_client_res  = 1'b1;
      b_ip_resolved = 1'b1;
      b_web_ip      = 8'h99;
      step();
      b_client_res  = 1'b0;
      b_ip_resolved = 1'b0;
      b_web_ip      = '0;
      hits_v = 0;
      hits_r = 0;
      repeat (6) begin
         step();
         if (b_resp_valid === 1'b1) hits_v++;
         if (b_client_req === 1'b1) hits_r++;
      end
      chk("mid_no_resp", hits_v, 0);
      chk("mid_no_req", hits_r, 0);
      chk("mid_pending0", b_pending, 0);
      chk("mid_resp_ip", b_resp_ip, 0);
      chk("mid_ready", b_enq_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
